// File: rtl/vga_pixel_fetch_pkg.sv
// Shared constants, colour type and intensity-to-colour helpers for the VGA pixel fetch path.
// Reset colours and offset are what the shadow registers hold until the first VS rising edge.
package vga_pixel_fetch_pkg;

    localparam int unsigned SRC_W_DEF   = 512;
    localparam int unsigned SRC_H_DEF   = 256;
    localparam int unsigned ADDR_W_DEF  = 17;
    localparam int unsigned MEM_LAT_DEF = 2;

    typedef logic [23:0] colour_t;

    localparam logic [11:0] RST_Y_OFFSET = 12'd44;
    localparam colour_t     RST_FG       = 24'hFF_FF_FF;
    localparam colour_t     RST_BORDER   = 24'h00_00_00;

    function automatic logic [7:0] chan_r(colour_t c);
        return c[23:16];
    endfunction

    function automatic logic [7:0] chan_g(colour_t c);
        return c[15:8];
    endfunction

    function automatic logic [7:0] chan_b(colour_t c);
        return c[7:0];
    endfunction

    // Full intensity passes the channel through untouched; otherwise c * {i,i} / 256.
    function automatic logic [7:0] scale_chan(logic [7:0] c, logic [3:0] i);
        if (i == 4'hF) begin
            return c;
        end
        return 8'((16'(c) * 16'({i, i})) >> 8);
    endfunction

    function automatic colour_t scale_colour(colour_t c, logic [3:0] i);
        return {scale_chan(chan_r(c), i), scale_chan(chan_g(c), i), scale_chan(chan_b(c), i)};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Single-bit shift register used to carry syncs and per-pixel tags alongside the memory read.
// Synchronous active-high reset loads every stage with RST_VAL.
module vga_sync_delay #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {DEPTH{RST_VAL}};
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Fetches 2x-scaled intensity pixels from frame memory and emits RGB with syncs delayed to match.
// Fixed MEM_LAT+2 pipeline: stage 0 (address), MEM_LAT tag stages, colour stage.
module vga_pixel_fetch
    import vga_pixel_fetch_pkg::*;
#(
    parameter int unsigned SRC_W   = SRC_W_DEF,
    parameter int unsigned SRC_H   = SRC_H_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic              VIDEO_CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [11:0]       VGA_X_I,
    input  logic [11:0]       VGA_Y_I,
    input  logic              VGA_VISIBLE_I,
    input  logic              VGA_HS_I,
    input  logic              VGA_VS_I,
    input  logic [11:0]       CFG_Y_OFFSET,
    input  logic [23:0]       CFG_FG,
    input  logic [23:0]       CFG_BORDER,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RD_EN,
    input  logic [3:0]        MEM_DATA,
    output logic [7:0]        RGB_R,
    output logic [7:0]        RGB_G,
    output logic [7:0]        RGB_B,
    output logic              HS_O,
    output logic              VS_O,
    output logic              DE_O,
    output logic              FRAME_DONE
);

    localparam int unsigned XW = $clog2(SRC_W);
    localparam int unsigned YW = ADDR_W - XW;
    localparam logic [12:0] IMG_W = 13'(2 * SRC_W);
    localparam logic [12:0] IMG_H = 13'(2 * SRC_H);

    // Shadow configuration, only updated on the VS rising edge.
    logic        vs_prev;
    logic [11:0] off;
    colour_t     fg;
    colour_t     border;

    always_ff @(posedge VIDEO_CLK) begin
        if (RESET) begin
            vs_prev <= 1'b0;
            off     <= RST_Y_OFFSET;
            fg      <= RST_FG;
            border  <= RST_BORDER;
        end else begin
            vs_prev <= VGA_VS_I;
            if (VGA_VS_I && !vs_prev) begin
                off    <= CFG_Y_OFFSET;
                fg     <= CFG_FG;
                border <= CFG_BORDER;
            end
        end
    end

    // 13-bit arithmetic keeps off + IMG_H from wrapping.
    logic [12:0] x13;
    logic [12:0] y13;
    logic [12:0] off13;
    logic [12:0] img_end;
    logic [12:0] ydiff;
    logic        de_in;
    logic        in_img;
    logic        last_px;

    always_comb begin
        x13     = {1'b0, VGA_X_I};
        y13     = {1'b0, VGA_Y_I};
        off13   = {1'b0, off};
        img_end = off13 + IMG_H;
        ydiff   = y13 - off13;
        de_in   = VGA_VISIBLE_I & ENABLE;
        in_img  = de_in && (x13 < IMG_W) && (y13 >= off13) && (y13 < img_end);
        last_px = in_img && (x13 == IMG_W - 13'd1) && (y13 == img_end - 13'd1);
    end

    // Only the scaled row/column bits form the address; the rest is deliberately dropped.
    logic [12:0] unused_ydiff;
    assign unused_ydiff = ydiff;

    always_ff @(posedge VIDEO_CLK) begin
        if (RESET) begin
            MEM_ADDR  <= '0;
            MEM_RD_EN <= 1'b0;
        end else begin
            MEM_RD_EN <= in_img;
            if (in_img) begin
                MEM_ADDR <= {ydiff[YW:1], VGA_X_I[XW:1]};
            end
        end
    end

    logic de_tag;
    logic img_tag;
    logic last_tag;

    vga_sync_delay #(.DEPTH(MEM_LAT + 1), .RST_VAL(1'b0)) u_de_dly (
        .clk (VIDEO_CLK),
        .rst (RESET),
        .d   (de_in),
        .q   (de_tag)
    );

    vga_sync_delay #(.DEPTH(MEM_LAT + 1), .RST_VAL(1'b0)) u_img_dly (
        .clk (VIDEO_CLK),
        .rst (RESET),
        .d   (in_img),
        .q   (img_tag)
    );

    vga_sync_delay #(.DEPTH(MEM_LAT + 1), .RST_VAL(1'b0)) u_last_dly (
        .clk (VIDEO_CLK),
        .rst (RESET),
        .d   (last_px),
        .q   (last_tag)
    );

    // Syncs skip the colour stage, so they take the whole MEM_LAT+2 in one shift register.
    vga_sync_delay #(.DEPTH(MEM_LAT + 2), .RST_VAL(1'b1)) u_hs_dly (
        .clk (VIDEO_CLK),
        .rst (RESET),
        .d   (VGA_HS_I),
        .q   (HS_O)
    );

    vga_sync_delay #(.DEPTH(MEM_LAT + 2), .RST_VAL(1'b0)) u_vs_dly (
        .clk (VIDEO_CLK),
        .rst (RESET),
        .d   (VGA_VS_I),
        .q   (VS_O)
    );

    colour_t rgb;

    always_ff @(posedge VIDEO_CLK) begin
        if (RESET) begin
            rgb        <= '0;
            DE_O       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            DE_O       <= de_tag;
            FRAME_DONE <= last_tag;
            if (!de_tag) begin
                rgb <= '0;
            end else if (!img_tag) begin
                rgb <= border;
            end else begin
                rgb <= scale_colour(fg, MEM_DATA);
            end
        end
    end

    assign RGB_R = chan_r(rgb);
    assign RGB_G = chan_g(rgb);
    assign RGB_B = chan_b(rgb);

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch at a reduced source size (64x32) so whole frames stay short.
module tb_vga_pixel_fetch;

    localparam int SRC_W   = 64;
    localparam int SRC_H   = 32;
    localparam int ADDR_W  = 11;
    localparam int MEM_LAT = 2;
    localparam int H_TOTAL = 148;
    localparam int H_VIS   = 136;
    localparam int V_TOTAL = 116;
    localparam int V_VIS   = 112;

    typedef struct packed {
        logic              vis;
        logic              en;
        logic [11:0]       x;
        logic [11:0]       y;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic              de;
        logic [23:0]       rgb;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [11:0]       x;
    logic [11:0]       y;
    logic              vis;
    logic              hs;
    logic              vs;
    logic [11:0]       cfg_off;
    logic [23:0]       cfg_fg;
    logic [23:0]       cfg_border;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [3:0]        mem_data;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
    logic              hs_o;
    logic              vs_o;
    logic              de_o;
    logic              frame_done;
    logic [23:0]       rgb;

    int n_vec = 0;
    int n_err = 0;

    assign rgb = {r, g, b};

    always #5 clk = ~clk;

    vga_pixel_fetch #(
        .SRC_W   (SRC_W),
        .SRC_H   (SRC_H),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .VIDEO_CLK     (clk),
        .RESET         (rst),
        .ENABLE        (en),
        .VGA_X_I       (x),
        .VGA_Y_I       (y),
        .VGA_VISIBLE_I (vis),
        .VGA_HS_I      (hs),
        .VGA_VS_I      (vs),
        .CFG_Y_OFFSET  (cfg_off),
        .CFG_FG        (cfg_fg),
        .CFG_BORDER    (cfg_border),
        .MEM_ADDR      (mem_addr),
        .MEM_RD_EN     (mem_rd_en),
        .MEM_DATA      (mem_data),
        .RGB_R         (r),
        .RGB_G         (g),
        .RGB_B         (b),
        .HS_O          (hs_o),
        .VS_O          (vs_o),
        .DE_O          (de_o),
        .FRAME_DONE    (frame_done)
    );

    // Two-cycle read latency memory model.
    logic [3:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] p1 = '0;
    logic [ADDR_W-1:0] p2 = '0;
    always @(posedge clk) begin
        p1 <= mem_addr;
        p2 <= p1;
    end
    assign mem_data = mem[p2];

    int          cyc = 0;
    int          rd_cnt;
    int          fd_cnt;
    int          fd_cyc;
    logic [23:0] fd_rgb;
    logic        clr = 1'b1;
    int          last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr) begin
            rd_cnt <= 0;
            fd_cnt <= 0;
            fd_cyc <= -1;
            fd_rgb <= '0;
        end else begin
            if (mem_rd_en) rd_cnt <= rd_cnt + 1;
            if (frame_done) begin
                fd_cnt <= fd_cnt + 1;
                fd_cyc <= cyc;
                fd_rgb <= rgb;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic e, input int xx, input int yy);
        vis = v;
        en  = e;
        x   = 12'(xx);
        y   = 12'(yy);
        hs  = 1'b1;
        vs  = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 0, 0);
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        tick();
        vs = 1'b0;
        tick();
    endtask

    function automatic vec_t mk(logic v, logic e, int xx, int yy, logic rd, int addr, logic de,
                                logic [23:0] c);
        return '{v, e, 12'(xx), 12'(yy), rd, ADDR_W'(addr), de, c};
    endfunction

    task automatic run_frame(input int off, input int abort_line);
        for (int yy = 0; yy < V_TOTAL; yy++) begin
            for (int xx = 0; xx < H_TOTAL; xx++) begin
                if (yy == abort_line && xx == 20) return;
                vis = (xx < H_VIS) && (yy < V_VIS);
                en  = 1'b1;
                x   = 12'(xx);
                y   = 12'(yy);
                hs  = !(xx >= 138 && xx < 142);
                vs  = (yy >= 113 && yy < 115);
                if (vis && xx == 2*SRC_W-1 && yy == off + 2*SRC_H - 1) last_cyc = cyc;
                tick();
            end
        end
        idle();
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 0, 44);
        tick();
        tick();
        n_vec++;
        if ({hs_o, vs_o, de_o, frame_done, mem_rd_en, rgb} !== {5'b10000, 24'h0}) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h",
                     {hs_o, vs_o, de_o, frame_done, mem_rd_en, rgb}, {5'b10000, 24'h0});
        end
        rst = 1'b0;
        drive(1'b1, 1'b1, 0, 44);
        tick();
        n_vec++;
        if ({mem_rd_en, mem_addr} !== {1'b1, 11'h000}) begin
            n_err++;
            $display("FAIL reset_offset_in: got %h want %h", {mem_rd_en, mem_addr}, {1'b1, 11'h000});
        end
        drive(1'b1, 1'b1, 0, 43);
        tick();
        n_vec++;
        if (mem_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_offset_out: got rd=%b want 0", mem_rd_en);
        end
        idle();
        tick();
        tick();
        n_vec++;
        if ({de_o, rgb} !== {1'b1, 24'hFFFFFF}) begin
            n_err++;
            $display("FAIL reset_fg: got %h want %h", {de_o, rgb}, {1'b1, 24'hFFFFFF});
        end
        tick();
        n_vec++;
        if ({de_o, rgb} !== {1'b1, 24'h000000}) begin
            n_err++;
            $display("FAIL reset_border: got %h want %h", {de_o, rgb}, {1'b1, 24'h000000});
        end
    endtask

    task automatic test_pixel();
        cfg_fg     = 24'hFF8000;
        cfg_border = 24'h102030;
        cfg_off    = 12'd44;
        vs_pulse();
        drive(1'b1, 1'b1, 6, 46);
        tick();
        n_vec++;
        if ({mem_rd_en, mem_addr} !== {1'b1, 11'h043}) begin
            n_err++;
            $display("FAIL pixel_addr: got %h want %h", {mem_rd_en, mem_addr}, {1'b1, 11'h043});
        end
        idle();
        tick();
        n_vec++;
        if ({mem_rd_en, mem_addr} !== {1'b0, 11'h043}) begin
            n_err++;
            $display("FAIL addr_hold: got %h want %h", {mem_rd_en, mem_addr}, {1'b0, 11'h043});
        end
        tick();
        n_vec++;
        if ({de_o, rgb} !== 25'h0) begin
            n_err++;
            $display("FAIL pixel_early: got %h want %h", {de_o, rgb}, 25'h0);
        end
        tick();
        n_vec++;
        if ({de_o, rgb} !== {1'b1, 24'hFF8000}) begin
            n_err++;
            $display("FAIL pixel_fg: got %h want %h", {de_o, rgb}, {1'b1, 24'hFF8000});
        end
        tick();
        n_vec++;
        if ({de_o, rgb} !== 25'h0) begin
            n_err++;
            $display("FAIL pixel_after: got %h want %h", {de_o, rgb}, 25'h0);
        end
    endtask

    task automatic test_scale();
        vec_t t [4];
        cfg_fg = 24'hFFFFFF;
        vs_pulse();
        t[0] = mk(1'b1, 1'b1, 10, 50, 1'b1, 'h0C5, 1'b1, 24'h878787);
        t[1] = mk(1'b1, 1'b1, 12, 50, 1'b1, 'h0C6, 1'b1, 24'h000000);
        t[2] = mk(1'b1, 1'b1, 14, 50, 1'b1, 'h0C7, 1'b1, 24'h101010);
        t[3] = mk(1'b1, 1'b1, 6, 46, 1'b1, 'h043, 1'b1, 24'hFFFFFF);
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(t[i].vis, t[i].en, int'(t[i].x), int'(t[i].y));
            else idle();
            tick();
            if (i < 4) begin
                n_vec++;
                if (mem_rd_en !== t[i].rd || mem_addr !== t[i].addr) begin
                    n_err++;
                    $display("FAIL scale_addr[%0d]: got %h want %h", i, {mem_rd_en, mem_addr},
                             {t[i].rd, t[i].addr});
                end
            end
            if (i >= 3) begin
                n_vec++;
                if ({de_o, rgb} !== {t[i-3].de, t[i-3].rgb}) begin
                    n_err++;
                    $display("FAIL scale_rgb[%0d]: got %h want %h", i - 3, {de_o, rgb},
                             {t[i-3].de, t[i-3].rgb});
                end
            end
        end
    endtask

    task automatic test_outside();
        vec_t t [8];
        t[0] = mk(1'b1, 1'b1, 128, 50, 1'b0, 0, 1'b1, 24'h102030);
        t[1] = mk(1'b1, 1'b1, 0, 40, 1'b0, 0, 1'b1, 24'h102030);
        t[2] = mk(1'b1, 1'b1, 127, 107, 1'b1, 'h7FF, 1'b1, 24'hFFFFFF);
        t[3] = mk(1'b1, 1'b1, 127, 108, 1'b0, 0, 1'b1, 24'h102030);
        t[4] = mk(1'b0, 1'b1, 5, 50, 1'b0, 0, 1'b0, 24'h000000);
        t[5] = mk(1'b1, 1'b0, 6, 46, 1'b0, 0, 1'b0, 24'h000000);
        t[6] = mk(1'b1, 1'b1, 6, 46, 1'b1, 'h043, 1'b1, 24'hFFFFFF);
        t[7] = mk(1'b1, 1'b0, 8, 46, 1'b0, 0, 1'b0, 24'h000000);
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(t[i].vis, t[i].en, int'(t[i].x), int'(t[i].y));
            else idle();
            tick();
            if (i < 8) begin
                n_vec++;
                if (mem_rd_en !== t[i].rd || (t[i].rd && mem_addr !== t[i].addr)) begin
                    n_err++;
                    $display("FAIL outside_rd[%0d]: got %h want %h", i, {mem_rd_en, mem_addr},
                             {t[i].rd, t[i].addr});
                end
            end
            if (i >= 3) begin
                n_vec++;
                if ({de_o, rgb} !== {t[i-3].de, t[i-3].rgb}) begin
                    n_err++;
                    $display("FAIL outside_rgb[%0d]: got %h want %h", i - 3, {de_o, rgb},
                             {t[i-3].de, t[i-3].rgb});
                end
            end
        end
    endtask

    task automatic test_sync();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                drive(1'b1, 1'b0, 6, 46);
                hs = 1'b0;
                vs = 1'b1;
            end else begin
                idle();
            end
            tick();
            n_vec++;
            if ({hs_o, vs_o, de_o, mem_rd_en, rgb} !== {(i != 3), (i == 3), 2'b00, 24'h0}) begin
                n_err++;
                $display("FAIL sync_delay[%0d]: got %h want %h", i,
                         {hs_o, vs_o, de_o, mem_rd_en, rgb}, {(i != 3), (i == 3), 2'b00, 24'h0});
            end
        end
    endtask

    task automatic test_cfg_shadow();
        cfg_fg = 24'h00FF00;
        drive(1'b1, 1'b1, 6, 46);
        tick();
        idle();
        repeat (3) tick();
        n_vec++;
        if ({de_o, rgb} !== {1'b1, 24'hFFFFFF}) begin
            n_err++;
            $display("FAIL cfg_midframe: got %h want %h", {de_o, rgb}, {1'b1, 24'hFFFFFF});
        end
        vs     = 1'b1;
        cfg_fg = 24'h0000FF;
        tick();
        vs     = 1'b0;
        cfg_fg = 24'h00FF00;
        tick();
        drive(1'b1, 1'b1, 6, 46);
        tick();
        idle();
        repeat (3) tick();
        n_vec++;
        if ({de_o, rgb} !== {1'b1, 24'h0000FF}) begin
            n_err++;
            $display("FAIL cfg_vs_edge: got %h want %h", {de_o, rgb}, {1'b1, 24'h0000FF});
        end
    endtask

    task automatic check_frame(input string name, input int exp_rd, input int exp_fd,
                               input logic [23:0] exp_rgb);
        n_vec++;
        if (rd_cnt !== exp_rd) begin
            n_err++;
            $display("FAIL %s_reads: got %0d want %0d", name, rd_cnt, exp_rd);
        end
        n_vec++;
        if (fd_cnt !== exp_fd) begin
            n_err++;
            $display("FAIL %s_done_count: got %0d want %0d", name, fd_cnt, exp_fd);
        end
        if (exp_fd == 1) begin
            n_vec++;
            if (fd_cyc - last_cyc !== 4 || fd_rgb !== exp_rgb) begin
                n_err++;
                $display("FAIL %s_done_pixel: got lat=%0d rgb=%h want lat=4 rgb=%h", name,
                         fd_cyc - last_cyc, fd_rgb, exp_rgb);
            end
        end
    endtask

    task automatic test_frame();
        cfg_fg  = 24'hFF8000;
        cfg_off = 12'd44;
        vs_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        last_cyc = -100;
        run_frame(44, -1);
        check_frame("frame", 2*SRC_W * 2*SRC_H, 1, 24'hFF8000);
    endtask

    task automatic test_clip();
        cfg_off = 12'd60;
        vs_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run_frame(60, -1);
        // Rows 60..111 are visible: 52 scaled lines of 128 pixels.
        check_frame("clip", 2*SRC_W * (V_VIS - 60), 0, 24'h0);
    endtask

    task automatic test_reset_midframe();
        cfg_off = 12'd44;
        vs_pulse();
        run_frame(44, 60);
        rst = 1'b1;
        tick();
        n_vec++;
        if ({hs_o, vs_o, de_o, frame_done, mem_rd_en, rgb} !== {5'b10000, 24'h0}) begin
            n_err++;
            $display("FAIL midframe_reset: got %h want %h",
                     {hs_o, vs_o, de_o, frame_done, mem_rd_en, rgb}, {5'b10000, 24'h0});
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({de_o, frame_done, mem_rd_en, rgb} !== 27'h0) begin
                n_err++;
                $display("FAIL flush[%0d]: got %h want %h", i, {de_o, frame_done, mem_rd_en, rgb},
                         27'h0);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        last_cyc = -100;
        run_frame(44, -1);
        // Shadow fg is back at its reset value even though CFG_FG still holds FF8000.
        check_frame("restart", 2*SRC_W * 2*SRC_H, 1, 24'hFFFFFF);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 4'(i);
        mem['h000] = 4'hF;
        mem['h043] = 4'hF;
        mem['h0C5] = 4'h8;
        mem['h0C6] = 4'h0;
        mem['h0C7] = 4'h1;
        mem['h7FF] = 4'hF;
        cfg_off    = 12'd44;
        cfg_fg     = 24'hFFFFFF;
        cfg_border = 24'h000000;
        last_cyc   = -100;
        test_reset();
        test_pixel();
        test_scale();
        test_outside();
        test_sync();
        test_cfg_shadow();
        test_frame();
        test_clip();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
